fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode; it replaces a bare IF/ID register.
- Captures {pc, pc_plus4, instr} beats from fetch and presents them in order to decode.
- Valid/ready handshake on both sides; discards all contents on branch flush.
- Decouples fetch from decode stalls, so fetch write-enable becomes in_ready instead of ~(stall || flush).

---
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue (circular buffer of {pc, pc_plus4, instr}); optional FETCH_QUEUE_STATS_EN adds flush_drops.
// Latency: a beat pushed at edge N is visible at the head after edge N; there is no in->out bypass.
// Backpressure: in_ready = not full, independent of out_ready; flush empties the queue and drops the incoming beat.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_pc_plus4,
  input  logic [31:0]                  in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_plus4,
  output logic [31:0]                  out_instr,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [15:0]                  flush_drops,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  fq_entry_t         wr_dat;
  fq_entry_t         head;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_dat   = '{pc: in_pc, pc_plus4: in_pc_plus4, instr: in_instr};
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset; an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (out_valid) begin
      out_pc       = head.pc;
      out_pc_plus4 = head.pc_plus4;
      out_instr    = head.instr;
    end else begin
      out_pc       = 32'h0;
      out_pc_plus4 = 32'h0;
      out_instr    = NOP_INSTR;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_drops_q, flush_drops_d;
  logic [16:0] drops_sum;

  always_comb begin
    drops_sum     = {1'b0, flush_drops_q} + 17'(count_q);
    flush_drops_d = flush_drops_q;
    if (flush) flush_drops_d = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flush_drops_q <= 16'h0;
    else       flush_drops_q <= flush_drops_d;
  end

  assign flush_drops = flush_drops_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_pc, in_pc_plus4, in_instr, out_pc, out_pc_plus4, out_instr;
  logic [CW-1:0] count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0]   flush_drops;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
`ifdef FETCH_QUEUE_STATS_EN
    .flush_drops(flush_drops),
`endif
    .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } beat_t;

  beat_t mq[$];
  int    exp_drops = 0;
  int    checks    = 0;
  int    failures  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready",  32'(in_ready),  32'(n < DEPTH));
    chk("count",     32'(count),     32'(n));
    if (n > 0) begin
      chk("out_pc",       out_pc,       mq[0].pc);
      chk("out_pc_plus4", out_pc_plus4, mq[0].pc4);
      chk("out_instr",    out_instr,    mq[0].instr);
    end else begin
      chk("out_pc_idle",       out_pc,       32'h0);
      chk("out_pc_plus4_idle", out_pc_plus4, 32'h0);
      chk("out_instr_idle",    out_instr,    NOP);
    end
`ifdef FETCH_QUEUE_STATS_EN
    chk("flush_drops", 32'(flush_drops), 32'(exp_drops));
`endif
  endtask

  // Check the current state, advance the model by the rules for this cycle's inputs, then step the clock.
  task automatic tick();
    int    n;
    bit    do_pop, do_push;
    beat_t b;
    @(negedge clk);
    check_outputs();
    n = mq.size();
    if (reset) begin
      mq.delete();
      exp_drops = 0;
    end else if (flush) begin
      exp_drops = (exp_drops + n > 65535) ? 65535 : exp_drops + n;
      mq.delete();
    end else begin
      do_pop  = (n > 0) && out_ready;
      do_push = in_valid && (n < DEPTH);
      b.pc = in_pc; b.pc4 = in_pc_plus4; b.instr = in_instr;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid    = v;
    in_pc       = pc;
    in_pc_plus4 = pc + 32'd4;
    in_instr    = instr;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_instr", out_instr, 32'h00000013);
    chk("rst_pc", out_pc, 32'h0);

    // In-order drain of three beats.
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 32'(4 * k), 32'hA0 + 32'(4 * k));
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    chk("t2_count", 32'(count), 32'h3);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t2_pop_pc", out_pc, 32'(4 * k));
      chk("t2_pop_instr", out_instr, 32'hA0 + 32'(4 * k));
      tick();
    end
    chk("t2_empty", 32'(out_valid), 32'h0);

    // Fill, hold a fifth beat off, then free one slot.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 32'h10 + 32'(4 * k), 32'hB0 + 32'(k));
      tick();
    end
    chk("t3_full_count", 32'(count), 32'h4);
    chk("t3_full_ready", 32'(in_ready), 32'h0);
    offer(1'b1, 32'h50, 32'hB4);
    tick();
    chk("t3_still_full", 32'(count), 32'h4);
    chk("t3_head", out_pc, 32'h10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ready_after_pop", 32'(in_ready), 32'h1);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("t3_refill", 32'(count), 32'h4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Streaming at one beat per cycle.
    for (int k = 0; k < 10; k++) begin
      offer(1'b1, 32'h100 + 32'(4 * k), 32'hC0 + 32'(k));
      tick();
      chk("t4_count", 32'(count), 32'h1);
      chk("t4_pc", out_pc, 32'h100 + 32'(4 * k));
    end
    offer(1'b0, 32'h0, 32'h0);
    tick();

    // Flush with three held beats and a concurrent offer.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 32'h300 + 32'(4 * k), 32'hD0);
      tick();
    end
    offer(1'b1, 32'h40, 32'hDEAD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_valid", 32'(out_valid), 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("t5_drops", 32'(flush_drops), 32'h3);
`endif
    offer(1'b1, 32'h200, 32'hE0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("t5_new_head", out_pc, 32'h200);

    // Reset and flush together with two beats held.
    offer(1'b1, 32'h204, 32'hE4);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("t6_pre_count", 32'(count), 32'h2);
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_ready", 32'(in_ready), 32'h1);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      offer(1'($urandom_range(0, 3) != 0), $urandom, $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
